// File: rtl/text_console_writer_pkg.sv
// Shared console geometry, control-character codes and writer state encoding.
// Included by the text console writer and by anything that addresses the tile memory.
package text_console_writer_pkg;

  localparam int TXT_FONT_W = 8;
  localparam int TXT_COLS   = 20;
  localparam int TXT_ROWS   = 15;

  localparam int ASCII_BS    = 'h08;
  localparam int ASCII_LF    = 'h0A;
  localparam int ASCII_FF    = 'h0C;
  localparam int ASCII_CR    = 'h0D;
  localparam int ASCII_SPACE = 'h20;
  localparam int ASCII_TILDE = 'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_ALL,
    ST_CLR_LINE
  } wr_state_t;

endpackage

// File: rtl/text_console_writer.sv
// Converts a valid/ready stream of ASCII codes into tile-memory write cycles,
// tracking a wrapping text cursor and running full-screen / single-line clears.
module text_console_writer
  import text_console_writer_pkg::*;
#(
  parameter int COLS       = TXT_COLS,
  parameter int ROWS       = TXT_ROWS,
  parameter int FONT_WIDTH = TXT_FONT_W,
  parameter int ADDR_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FONT_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [FONT_WIDTH-1:0] wr_data,
  output logic [4:0]            cur_col,
  output logic [3:0]            cur_row,
  output logic                  busy
);

  localparam int CELLS = COLS * ROWS;
  // One extra bit so the clear index can reach CELLS even when CELLS == 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [FONT_WIDTH-1:0] CH_SPACE = FONT_WIDTH'(ASCII_SPACE);
  localparam logic [FONT_WIDTH-1:0] CH_TILDE = FONT_WIDTH'(ASCII_TILDE);
  localparam logic [FONT_WIDTH-1:0] CH_BS    = FONT_WIDTH'(ASCII_BS);
  localparam logic [FONT_WIDTH-1:0] CH_LF    = FONT_WIDTH'(ASCII_LF);
  localparam logic [FONT_WIDTH-1:0] CH_FF    = FONT_WIDTH'(ASCII_FF);
  localparam logic [FONT_WIDTH-1:0] CH_CR    = FONT_WIDTH'(ASCII_CR);

  wr_state_t        state;
  logic [CNT_W-1:0] clr_idx;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [3:0] row,
                                                  input logic [CNT_W-1:0] col);
    return ADDR_W'(int'(row) * COLS + int'(col));
  endfunction

  function automatic logic [3:0] next_row(input logic [3:0] row);
    return (row == 4'(ROWS - 1)) ? 4'd0 : row + 4'd1;
  endfunction

  assign in_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLR_ALL;
      clr_idx <= '0;
      cur_col <= '0;
      cur_row <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= CH_SPACE;
      busy    <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        // The terminal index issues no write, so busy stays high through the
        // cycle that presents the last clear write.
        ST_CLR_ALL: begin
          if (clr_idx == CNT_W'(CELLS)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_idx[ADDR_W-1:0];
            wr_data <= CH_SPACE;
            clr_idx <= clr_idx + 1'b1;
          end
        end

        ST_CLR_LINE: begin
          if (clr_idx == CNT_W'(COLS)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= tile_addr(cur_row, clr_idx);
            wr_data <= CH_SPACE;
            clr_idx <= clr_idx + 1'b1;
          end
        end

        ST_IDLE: begin
          if (in_valid) begin
            if (in_data >= CH_SPACE && in_data <= CH_TILDE) begin
              wr_en   <= 1'b1;
              wr_addr <= tile_addr(cur_row, CNT_W'(cur_col));
              wr_data <= in_data;
              if (cur_col < 5'(COLS - 1)) begin
                cur_col <= cur_col + 5'd1;
              end else begin
                cur_col <= '0;
                cur_row <= next_row(cur_row);
                clr_idx <= '0;
                state   <= ST_CLR_LINE;
                busy    <= 1'b1;
              end
            end else begin
              case (in_data)
                CH_CR: cur_col <= '0;
                CH_LF: begin
                  cur_col <= '0;
                  cur_row <= next_row(cur_row);
                  clr_idx <= '0;
                  state   <= ST_CLR_LINE;
                  busy    <= 1'b1;
                end
                CH_BS: begin
                  if (cur_col != 5'd0) begin
                    cur_col <= cur_col - 5'd1;
                    wr_en   <= 1'b1;
                    wr_addr <= tile_addr(cur_row, CNT_W'(cur_col - 5'd1));
                    wr_data <= CH_SPACE;
                  end
                end
                CH_FF: begin
                  cur_col <= '0;
                  cur_row <= '0;
                  clr_idx <= '0;
                  state   <= ST_CLR_ALL;
                  busy    <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench for text_console_writer: a screen/cursor model predicts every
// tile write, and a monitor compares each wr_en cycle against the predictions.
module tb_text_console_writer;

  localparam int COLS  = 20;
  localparam int ROWS  = 15;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] cur_col;
  logic [3:0] cur_row;
  logic       busy;

  text_console_writer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit clr;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  m_col  = 0;
  int  m_row  = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void push_wr(input int addr, input int data, input bit clr);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.clr  = clr;
    exp_q.push_back(e);
  endfunction

  function automatic void push_line(input int row);
    for (int c = 0; c < COLS; c++) push_wr(row * COLS + c, 'h20, 1'b1);
  endfunction

  function automatic void push_all();
    for (int a = 0; a < CELLS; a++) push_wr(a, 'h20, 1'b1);
  endfunction

  // Behavioural console: cursor as plain integers, screen effects as write lists.
  function automatic bit model(input logic [7:0] c);
    bit imm = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr(m_row * COLS + m_col, int'(c), 1'b0);
      imm = 1'b1;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_line(m_row);
      end
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      push_line(m_row);
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_row * COLS + m_col, 'h20, 1'b0);
        imm = 1'b1;
      end
    end else if (c == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      push_all();
    end
    return imm;
  endfunction

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_write", int'(wr_addr), -1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check(int'(wr_addr) == e.addr, "wr_addr", int'(wr_addr), e.addr);
        check(int'(wr_data) == e.data, "wr_data", int'(wr_data), e.data);
        if (e.clr)
          check(busy && !in_ready, "clear_busy", int'({busy, in_ready}), 2);
      end
    end
  end

  task automatic check_cursor(input string name);
    check(int'(cur_col) == m_col && int'(cur_row) == m_row, name,
          int'(cur_row) * 256 + int'(cur_col), m_row * 256 + m_col);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    bit imm;
    @(negedge clk);
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check(1'b0, "in_ready_timeout", 0, 1);
      return;
    end
    in_data  = c;
    in_valid = 1'b1;
    imm = model(c);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check(wr_en == imm, "write_latency", int'(wr_en), int'(imm));
    check_cursor("cursor");
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    #1;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    check(!busy && in_ready && !wr_en, "idle_after_drain",
          int'({busy, in_ready, wr_en}), 2);
  endtask

  task automatic check_reset_state();
    check(wr_en == 1'b0, "rst_wr_en", int'(wr_en), 0);
    check(wr_addr == 9'd0, "rst_wr_addr", int'(wr_addr), 0);
    check(wr_data == 8'h20, "rst_wr_data", int'(wr_data), 'h20);
    check(busy == 1'b1, "rst_busy", int'(busy), 1);
    check(cur_col == 5'd0 && cur_row == 4'd0, "rst_cursor",
          int'({cur_row, cur_col}), 0);
  endtask

  initial begin
    int n;
    logic [7:0] c;
    int r;

    // Power-on reset and the full-screen clear it starts
    repeat (2) @(posedge clk);
    #1;
    check(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
    check_reset_state();
    push_all();
    @(negedge clk);
    rst = 1'b0;
    wait_drain();

    // Single glyph, then a full line forcing a wrap and line clear
    send(8'h41);
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h30 + 8'(i % 10));
    check(cur_col == 5'd0 && cur_row == 4'd1, "wrap_cursor",
          int'({cur_row, cur_col}), 32);
    wait_drain();

    // Walk to (5,14) then LF wraps to the top line
    for (int i = 0; i < 13; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    check(cur_col == 5'd5 && cur_row == 4'd14, "at_5_14",
          int'({cur_row, cur_col}), 14 * 32 + 5);
    send(8'h0A);
    check(cur_col == 5'd0 && cur_row == 4'd0, "lf_wrap",
          int'({cur_row, cur_col}), 0);
    wait_drain();

    // Backspace mid-line and at column 0
    send(8'h0A);
    send(8'h0A);
    send(8'h78);
    send(8'h79);
    send(8'h7A);
    send(8'h08);
    check(cur_col == 5'd2 && cur_row == 4'd2, "bs_cursor",
          int'({cur_row, cur_col}), 2 * 32 + 2);
    send(8'h0D);
    send(8'h08);
    wait_drain();

    // Form feed, then reset in the middle of the clear
    send(8'h0C);
    n = 0;
    while (!(wr_en && wr_addr == 9'd150) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(wr_en && wr_addr == 9'd150, "reach_addr150", int'(wr_addr), 150);
    #1;
    rst = 1'b1;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_all();
    @(negedge clk);
    check_reset_state();
    send(8'h07);
    wait_drain();

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60)      c = 8'($urandom_range(32, 126));
      else if (r < 70) c = 8'h0D;
      else if (r < 80) c = 8'h0A;
      else if (r < 92) c = 8'h08;
      else if (r < 94) c = 8'h0C;
      else if (r < 97) c = 8'($urandom_range(127, 255));
      else             c = 8'h07;
      send(c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
